// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Enumerations are used by both the top-level FSM and the round-robin arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Bit 0 of a request/grant vector is the IFU, bit 1 the LSU.
  function automatic grant_e onehot_to_grant(input logic [1:0] gnt);
    return gnt[1] ? GNT_LSU : GNT_IFU;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus the
// last-grant register that breaks ties in favour of the other requester.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  grant_e     update_grant,
  output logic [1:0] gnt
);

  grant_e last_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= GNT_IFU;
    end else if (update) begin
      last_q <= update_grant;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == GNT_IFU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the IFU and LSU, one transaction at a time.
// Optional watchdog on the WAIT state: define MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter int unsigned        TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]  ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_reqValid,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_respValid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_reqValid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  input  logic [1:0]        lsu_size,
  output logic              lsu_respValid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_reqValid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic [1:0]        mem_size,
  input  logic              mem_respValid,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARBITER_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);

  state_e            state_q, state_d;
  grant_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            terr_q;
  logic            timeout_fire;
`endif

  // Tie-break history only moves when a response is actually delivered.
  rr_arbiter2 u_rr_arbiter2 (
    .clock        (clock),
    .reset        (reset),
    .req          ({lsu_reqValid, ifu_reqValid}),
    .update       (state_q == RESP),
    .update_grant (owner_q),
    .gnt          (gnt)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    size_d  = size_q;
    rdata_d = rdata_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = onehot_to_grant(gnt);
          state_d = ISSUE;
          if (gnt[1]) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
            size_d  = lsu_size;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = 4'b0000;
            size_d  = SZ_W;
          end
        end
      end
      ISSUE: begin
        if (mem_respValid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_respValid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
`ifdef MEM_ARBITER_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d      = ERR_DATA;
          state_d      = RESP;
          timeout_fire = 1'b1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= GNT_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= 4'b0000;
      size_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  // Cleared during ISSUE so the first WAIT cycle sees a count of zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        cnt_q <= '0;
      end else if ((state_q == WAIT) && (cnt_q != {CntW{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
      terr_q <= terr_q | timeout_fire;
    end
  end

  assign timeout_err = terr_q;
`endif

  assign mem_reqValid  = (state_q == ISSUE);
  assign ifu_respValid = (state_q == RESP) && (owner_q == GNT_IFU);
  assign lsu_respValid = (state_q == RESP) && (owner_q == GNT_LSU);
  assign ifu_rdata     = rdata_q;
  assign lsu_rdata     = rdata_q;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign mem_size      = size_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a timestamp-based transaction model.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic [1:0]  lsu_size = '0;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  mem_size;
  logic        mem_respValid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clock = ~clock;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_size      (lsu_size),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_size      (mem_size),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
`ifdef MEM_ARBITER_TIMEOUT_EN
    .timeout_err   (timeout_err),
`endif
    .busy          (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // A transaction is a grant cycle, an issue cycle (grant+1) and a response cycle
  // (one after the memory answers, or after the watchdog expires).
  int          c = 0;
  bit          m_busy = 0;
  bit          m_owner = 0;        // 0 = IFU, 1 = LSU
  bit          m_last = 0;
  int          m_issue_at = 0;
  int          m_resp_at = -1;
  logic [31:0] m_data = '0;
  logic [31:0] m_addr = '0;
  bit          m_wen = 0;
  logic [31:0] m_wdata = '0;
  bit          m_wdata_known = 1;
  logic [3:0]  m_wmask = '0;
  logic [1:0]  m_size = '0;
  bit          m_terr = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_last = 0; m_owner = 0; m_resp_at = -1; m_data = '0;
      m_addr = '0; m_wen = 0; m_wdata = '0; m_wdata_known = 1; m_wmask = '0; m_size = '0;
      m_terr = 0;
    end else begin
      if (!m_busy) begin
        if (ifu_reqValid || lsu_reqValid) begin
          if (ifu_reqValid && lsu_reqValid) m_owner = ~m_last;
          else m_owner = lsu_reqValid;
          m_busy = 1; m_issue_at = c + 1; m_resp_at = -1;
          if (m_owner) begin
            m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wdata_known = 1;
            m_wmask = lsu_wmask; m_size = lsu_size;
          end else begin
            m_addr = ifu_addr; m_wen = 0; m_wdata_known = 0; m_wmask = 4'b0000; m_size = 2'd2;
          end
        end
      end else if (c == m_resp_at) begin
        m_busy = 0;
        m_last = m_owner;
      end else if (c >= m_issue_at && m_resp_at < 0) begin
        if (mem_respValid) begin
          m_data = mem_rdata; m_resp_at = c + 1;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (c == m_issue_at + int'(TO)) begin
          m_data = 32'hDEADBEEF; m_resp_at = c + 1; m_terr = 1;
        end
`endif
      end
      c++;
    end
  end

  // ---------------- memory responder and per-cycle compare ----------------
  int          mem_fixed_delay = 1;   // -1: random
  bit          mem_never = 0;
  logic [31:0] mem_data_val = '0;
  bit          stray_en = 0;
  bit          stray_once = 0;
  bit          mem_pend = 0;
  int          mem_due = 0;

  int n_ifu_resp = 0, n_lsu_resp = 0, n_memreq = 0;
  bit seen_ifu, seen_lsu, drop_ifu, drop_lsu;
  logic [31:0] snap_addr, snap_wdata, snap_rdata;
  logic        snap_wen;
  logic [3:0]  snap_wmask;
  logic [1:0]  snap_size;
  logic [31:0] issue_log[$];

  task automatic compare_all();
    bit in_resp;
    in_resp = m_busy && (c == m_resp_at);
    check("mem_reqValid", mem_reqValid, m_busy && (c == m_issue_at));
    check("busy", busy, m_busy);
    check("ifu_respValid", ifu_respValid, in_resp && !m_owner);
    check("lsu_respValid", lsu_respValid, in_resp && m_owner);
    check("ifu_rdata", ifu_rdata, m_data);
    check("lsu_rdata", lsu_rdata, m_data);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wen", mem_wen, m_wen);
    if (m_wdata_known) check("mem_wdata", mem_wdata, m_wdata);
    check("mem_wmask", mem_wmask, m_wmask);
    check("mem_size", mem_size, m_size);
`ifdef MEM_ARBITER_TIMEOUT_EN
    check("timeout_err", timeout_err, m_terr);
`endif
  endtask

  task automatic step();
    @(negedge clock);
    if (reset) compare_all();
    seen_ifu = ifu_respValid; seen_lsu = lsu_respValid;
    if (mem_reqValid) begin
      n_memreq++;
      snap_addr = mem_addr; snap_wen = mem_wen; snap_wdata = mem_wdata;
      snap_wmask = mem_wmask; snap_size = mem_size;
      issue_log.push_back(mem_addr);
    end
    if (seen_ifu) begin n_ifu_resp++; snap_rdata = ifu_rdata; end
    if (seen_lsu) begin n_lsu_resp++; snap_rdata = lsu_rdata; end
    mem_respValid = 1'b0;
    if (reset && m_busy && c == m_issue_at && !mem_never) begin
      mem_pend = 1;
      if (mem_fixed_delay >= 0) mem_due = c + mem_fixed_delay;
      else mem_due = c + (($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)));
    end
    if (stray_once) begin
      mem_respValid = 1'b1; mem_rdata = $urandom; stray_once = 0;
    end else if (mem_pend && c == mem_due) begin
      mem_respValid = 1'b1;
      mem_rdata = (mem_fixed_delay >= 0) ? mem_data_val : $urandom;
      mem_pend = 0;
    end else if (stray_en && (!m_busy || c == m_resp_at) && $urandom_range(0, 7) == 0) begin
      mem_respValid = 1'b1; mem_rdata = $urandom;
    end
    drop_ifu = seen_ifu; drop_lsu = seen_lsu;
    if (seen_ifu) ifu_reqValid = 1'b0;
    if (seen_lsu) lsu_reqValid = 1'b0;
  endtask

  // Raises one request in an IDLE cycle (cycle T) and runs until its response.
  task automatic do_txn(input bit lsu, input logic [31:0] addr, input bit wen,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic [1:0] size, input int delay, input logic [31:0] rd,
                        output int lat, output int nreq, output int nown, output int noth);
    int m0, i0, l0;
    step();
    mem_fixed_delay = delay; mem_data_val = rd;
    m0 = n_memreq; i0 = n_ifu_resp; l0 = n_lsu_resp;
    if (lsu) begin
      lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask; lsu_size = size;
      lsu_reqValid = 1'b1;
    end else begin
      ifu_addr = addr; ifu_reqValid = 1'b1;
    end
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if ((lsu && seen_lsu) || (!lsu && seen_ifu)) begin lat = k; break; end
    end
    if (lat < 0) check("txn_response_within_budget", 0, 1);
    step();
    nreq = n_memreq - m0;
    nown = lsu ? n_lsu_resp - l0 : n_ifu_resp - i0;
    noth = lsu ? n_ifu_resp - i0 : n_lsu_resp - l0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL global_time_limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  initial begin
    int lat, nreq, nown, noth, raises_i, raises_l, r0;

    repeat (3) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_mem_reqValid", mem_reqValid, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_ifu_rdata", ifu_rdata, 0);
    reset = 1'b1;

    // Simultaneous requests after reset: LSU first, then alternating.
    step();
    issue_log.delete();
    mem_fixed_delay = 1; mem_data_val = 32'h0000_1111;
    ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_0200;
    lsu_wen = 0; lsu_wmask = 4'hF; lsu_size = 2'd2; lsu_wdata = 32'h0;
    ifu_reqValid = 1; lsu_reqValid = 1;
    raises_i = 1; raises_l = 1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!ifu_reqValid && !drop_ifu && raises_i < 2) begin ifu_reqValid = 1; raises_i++; end
      if (!lsu_reqValid && !drop_lsu && raises_l < 2) begin lsu_reqValid = 1; raises_l++; end
      if (issue_log.size() >= 4 && !ifu_reqValid && !lsu_reqValid) break;
    end
    check("rr_count", issue_log.size(), 4);
    if (issue_log.size() >= 4) begin
      check("rr_order0_lsu", issue_log[0], 32'h8000_0200);
      check("rr_order1_ifu", issue_log[1], 32'h8000_0000);
      check("rr_order2_lsu", issue_log[2], 32'h8000_0200);
      check("rr_order3_ifu", issue_log[3], 32'h8000_0000);
    end

    // IFU only, memory answering one cycle after the request.
    do_txn(0, 32'h8000_0000, 0, 0, 0, 0, 1, 32'h0000_0413, lat, nreq, nown, noth);
    check("ifu_latency", lat, 3);
    check("ifu_rdata_value", snap_rdata, 32'h0000_0413);
    check("ifu_mem_addr", snap_addr, 32'h8000_0000);
    check("ifu_mem_wen", snap_wen, 0);
    check("ifu_mem_wmask", snap_wmask, 0);
    check("ifu_mem_size", snap_size, 2);
    check("ifu_single_issue", nreq, 1);
    check("ifu_no_lsu_resp", noth, 0);

    // LSU store.
    do_txn(1, 32'h8000_0100, 1, 32'hA5A5_A5A5, 4'b0011, 2'd1, 2, 32'h0, lat, nreq, nown, noth);
    check("st_mem_addr", snap_addr, 32'h8000_0100);
    check("st_mem_wen", snap_wen, 1);
    check("st_mem_wdata", snap_wdata, 32'hA5A5_A5A5);
    check("st_mem_wmask", snap_wmask, 4'b0011);
    check("st_mem_size", snap_size, 1);
    check("st_single_issue", nreq, 1);
    check("st_one_resp", nown, 1);
    check("st_latency", lat, 4);

    // Slow memory (20 cycles) and same-cycle response.
    do_txn(0, 32'h8000_0040, 0, 0, 0, 0, 20, 32'hCAFE_0001, lat, nreq, nown, noth);
    check("slow_latency", lat, 22);
    check("slow_single_issue", nreq, 1);
    check("slow_rdata", snap_rdata, 32'hCAFE_0001);
    do_txn(1, 32'h8000_0300, 0, 0, 4'hF, 2'd2, 0, 32'h1234_5678, lat, nreq, nown, noth);
    check("fast_latency", lat, 2);
    check("fast_rdata", snap_rdata, 32'h1234_5678);

    // Reset while waiting on memory.
    step();
    mem_fixed_delay = 20; ifu_addr = 32'h8000_0080; ifu_reqValid = 1;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem_reqValid", mem_reqValid, 0);
    check("rst_mid_ifu_respValid", ifu_respValid, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_ifu_rdata", ifu_rdata, 0);
    ifu_reqValid = 0; mem_pend = 0;
    step(); step();
    reset = 1'b1;
    r0 = n_ifu_resp + n_lsu_resp;
    repeat (25) step();
    check("rst_no_stale_resp", n_ifu_resp + n_lsu_resp - r0, 0);
    do_txn(0, 32'h8000_0084, 0, 0, 0, 0, 1, 32'h0BAD_F00D, lat, nreq, nown, noth);
    check("rst_after_latency", lat, 3);
    check("rst_after_rdata", snap_rdata, 32'h0BAD_F00D);

`ifdef MEM_ARBITER_TIMEOUT_EN
    mem_never = 1;
    do_txn(0, 32'h8000_0500, 0, 0, 0, 0, 1, 32'h0, lat, nreq, nown, noth);
    check("to_latency", lat, 2 + int'(TO));
    check("to_rdata", snap_rdata, 32'hDEAD_BEEF);
    check("to_err_set", timeout_err, 1);
    mem_never = 0;
    stray_once = 1;
    step(); step();
    check("to_late_resp_ignored_busy", busy, 0);
    check("to_err_sticky", timeout_err, 1);
`endif

    // Randomized traffic.
    mem_fixed_delay = -1; stray_en = 1;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (!ifu_reqValid && !drop_ifu && $urandom_range(0, 3) == 0) begin
        ifu_addr = $urandom; ifu_reqValid = 1;
      end
      if (!lsu_reqValid && !drop_lsu && $urandom_range(0, 3) == 0) begin
        lsu_addr = $urandom; lsu_wen = $urandom_range(0, 1); lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom); lsu_size = 2'($urandom_range(0, 2));
        lsu_reqValid = 1;
      end
    end
    stray_en = 0;
    for (int k = 0; k < 200; k++) begin
      if (!ifu_reqValid && !lsu_reqValid && !m_busy) break;
      step();
    end
    check("drain_idle", m_busy || ifu_reqValid || lsu_reqValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
